pool_out_writer: RTL

- Sink for the max-pooling stage's pooled lanes (`pooling_out` / `pooling_out_valid`).
- Packs `BEATS` consecutive pooled beats into one output-buffer word.
- Queues packed words in a small FIFO and writes them to the output feature-map buffer over a valid/ready write port, generating row/column addresses.
- Absorbs the no-backpressure pooling stream and raises a sticky overflow flag on loss.

---
 rtl/pool_out_writer_pkg.sv | 11 +
 rtl/pool_wr_fifo.sv | 47 ++++
 rtl/pool_out_writer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/pool_out_writer_pkg.sv
// pool_out_writer_pkg: shared lane width, FSM state type and beat/word width helpers
package pool_out_writer_pkg;
  localparam int LANE_W = 16;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  function automatic int beat_w(input int pox);
    return pox / 2 * LANE_W;
  endfunction
  function automatic int word_w(input int pox, input int beats);
    return beats * beat_w(pox);
  endfunction
endpackage

// File: rtl/pool_wr_fifo.sv
// pool_wr_fifo: synchronous show-ahead FIFO holding packed write words
//   clk, rst          clock, synchronous active-high reset
//   i_push, i_data    push request and word
//   i_pop             pop request (ignored when empty)
//   o_data            head entry (show-ahead)
//   o_full, o_empty   occupancy flags
//   o_one             exactly one entry held
// A push while full succeeds only when a pop frees the slot in the same cycle.
module pool_wr_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty,
  output logic         o_one
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0] r_wp, r_rp, w_cnt;
  logic w_push, w_pop;
  always_comb begin
    w_cnt   = r_wp - r_rp;
    o_empty = w_cnt == '0;
    o_full  = w_cnt == (AW+1)'(DEPTH);
    o_one   = w_cnt == (AW+1)'(1);
    w_pop   = i_pop && !o_empty;
    w_push  = i_push && (!o_full || w_pop);
    o_data  = r_mem[r_rp[AW-1:0]];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + (AW+1)'(1);
      if (w_pop) r_rp <= r_rp + (AW+1)'(1);
      if (w_push) r_mem[r_wp[AW-1:0]] <= i_data;
    end
  end
endmodule

// File: rtl/pool_out_writer.sv
// pool_out_writer: packs pooled beats into words and writes them out with raster addressing
//   clk, rst                 clock, synchronous active-high reset
//   pooling_out(_valid)      pooled lanes (lane 0 in LSBs), no backpressure
//   cfg_start, cfg_*         start pulse with base address, cols, rows, row stride
//   wr_valid/ready/addr/data output feature-map buffer write port
//   busy, done, overflow     run status; overflow is sticky until reset or next start
//   wr_count                 accepted-transfer count, present only with POOL_WR_CNT_EN
module pool_out_writer
  import pool_out_writer_pkg::*;
#(
  parameter int POX        = 4,
  parameter int BEATS      = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [beat_w(POX)-1:0]         pooling_out,
  input  logic                           pooling_out_valid,
  input  logic                           cfg_start,
  input  logic [ADDR_W-1:0]              cfg_base_addr,
  input  logic [7:0]                     cfg_cols,
  input  logic [7:0]                     cfg_rows,
  input  logic [ADDR_W-1:0]              cfg_row_stride,
  output logic                           wr_valid,
  input  logic                           wr_ready,
  output logic [ADDR_W-1:0]              wr_addr,
  output logic [word_w(POX,BEATS)-1:0]   wr_data,
  output logic                           busy,
  output logic                           done,
  output logic                           overflow
`ifdef POOL_WR_CNT_EN
  ,output logic [15:0]                   wr_count
`endif
);
  localparam int LW  = beat_w(POX);
  localparam int WW  = word_w(POX, BEATS);
  localparam int PCW = BEATS > 1 ? $clog2(BEATS) : 1;
  state_t r_state, w_nxt;
  logic [PCW-1:0] r_pack_cnt;
  logic [WW-1:0] r_pack_buf, w_word;
  logic [7:0] r_cols, r_col;
  logic [15:0] r_total, r_pushed;
  logic [ADDR_W-1:0] r_stride, r_addr, r_row_addr;
  logic r_ovf;
  logic w_start, w_beat, w_wrap, w_last_push, w_xfer, w_done, w_row_end;
  logic w_full, w_empty, w_one;
  always_comb begin
    w_start     = r_state == IDLE && cfg_start;
    w_beat      = r_state == RUN && pooling_out_valid;
    w_wrap      = w_beat && r_pack_cnt == PCW'(BEATS - 1);
    w_last_push = w_wrap && r_pushed == r_total - 16'd1;
    w_word      = r_pack_buf;
    w_word[r_pack_cnt * LW +: LW] = pooling_out;
    wr_valid    = !w_empty;
    w_xfer      = wr_valid && wr_ready;
    w_done      = r_state == DRAIN && w_xfer && w_one;
    w_row_end   = r_col == r_cols - 8'd1;
    w_nxt       = w_start ? RUN : w_last_push ? DRAIN : w_done ? IDLE : r_state;
    wr_addr     = r_addr;
    busy        = r_state != IDLE;
    done        = w_done;
    overflow    = r_ovf;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_pack_cnt <= '0;
      r_pack_buf <= '0;
      r_cols     <= '0;
      r_col      <= '0;
      r_total    <= '0;
      r_pushed   <= '0;
      r_stride   <= '0;
      r_addr     <= '0;
      r_row_addr <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (w_start) begin
        r_cols     <= cfg_cols;
        r_col      <= '0;
        r_total    <= 16'(cfg_cols) * 16'(cfg_rows);
        r_pushed   <= '0;
        r_stride   <= cfg_row_stride;
        r_addr     <= cfg_base_addr;
        r_row_addr <= cfg_base_addr;
        r_pack_cnt <= '0;
        r_ovf      <= 1'b0;
      end else begin
        if (w_beat) begin
          r_pack_buf <= w_word;
          r_pack_cnt <= w_wrap ? '0 : r_pack_cnt + PCW'(1);
        end
        // a dropped word still counts so the run always reaches rows*cols
        if (w_wrap) r_pushed <= r_pushed + 16'd1;
        if (w_wrap && w_full && !w_xfer) r_ovf <= 1'b1;
        if (w_xfer) begin
          r_col  <= w_row_end ? '0 : r_col + 8'd1;
          r_addr <= w_row_end ? r_row_addr + r_stride : r_addr + ADDR_W'(1);
          if (w_row_end) r_row_addr <= r_row_addr + r_stride;
        end
      end
    end
  end
`ifdef POOL_WR_CNT_EN
  logic [15:0] r_cnt;
  always_ff @(posedge clk) begin
    if (rst || w_start) r_cnt <= '0;
    else if (w_xfer && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
  end
  assign wr_count = r_cnt;
`endif
  pool_wr_fifo #(.W(WW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_wrap),
    .i_data  (w_word),
    .i_pop   (w_xfer),
    .o_data  (wr_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_one   (w_one)
  );
endmodule
